mips_mc_controller: RTL

//  Multi-cycle controller FSM for the next-generation MIPS core. It replaces the single-cycle decode-only controller.

---
 rtl/mips_pkg.sv | 79 +++++++
 rtl/mips_alu_decoder.sv | 36 +++
 rtl/mips_mc_controller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct codes, ALU control codes, datapath mux codes and the
// controller state/control-word types for the multi-cycle MIPS controller.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_ctl_t;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_RS     = 2'b11;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] REGDST_RT  = 2'b00;
   localparam logic [1:0] REGDST_RD  = 2'b01;
   localparam logic [1:0] REGDST_R31 = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;
   localparam logic [1:0] M2R_LUI    = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_WB_LUI, S_TRAP
   } state_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       pc_write;
      logic       pc_write_c;
      logic       beqorne;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_ctl;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       mem_err;
      logic       illegal;
   } ctl_t;

   function automatic logic is_mem_state(state_t s);
      return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
   endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decode: funct for R-type, opcode otherwise,
// plus a flag for any opcode/funct the controller does not implement.
module mips_alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic [3:0] alu_ctl_o,
   output logic       illegal_o
);

   always_comb begin
      alu_ctl_o = ALU_ADD;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD:  alu_ctl_o = ALU_ADD;
               FN_SUB:  alu_ctl_o = ALU_SUB;
               FN_AND:  alu_ctl_o = ALU_AND;
               FN_OR:   alu_ctl_o = ALU_OR;
               FN_SLT:  alu_ctl_o = ALU_SLT;
               FN_JR:   alu_ctl_o = ALU_ADD;
               default: illegal_o = 1'b1;
            endcase
         end
         OP_ADDI: alu_ctl_o = ALU_ADD;
         OP_ANDI: alu_ctl_o = ALU_AND;
         OP_ORI:  alu_ctl_o = ALU_OR;
         OP_SLTI: alu_ctl_o = ALU_SLT;
         OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_LUI: alu_ctl_o = ALU_ADD;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS controller FSM with ready-handshaked unified memory port.
// Optional MIPS_MC_TRAP_EN: illegal instructions take a TRAP state (PC <- vector).
module mips_mc_controller
   import mips_pkg::*;
#(
   parameter int unsigned ALUCTL_W    = 4,
   parameter int unsigned MEM_TIMEOUT = 0,
   parameter int unsigned TMO_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_read,
   output logic                mem_write,
   output logic                iord,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_write_c,
   output logic                beqorne,
   output logic [1:0]          pc_src,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUCTL_W-1:0] alu_ctl,
   output logic                reg_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                mem_err,
   output logic                illegal
);

`ifdef MIPS_MC_TRAP_EN
   localparam state_t ILL_NEXT = S_TRAP;
`else
   localparam state_t ILL_NEXT = S_FETCH;
`endif

   state_t           state_q, state_d;
   ctl_t             ctl_q, ctl_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic [3:0]       dec_alu;
   logic             dec_illegal;
   logic             in_mem, timeout, fetch_done;

   // Branch resolution on zero happens in the datapath via pc_write_c/beqorne.
   logic unused_zero;
   assign unused_zero = zero;

   mips_alu_decoder u_dec (
      .opcode_i  (opcode),
      .funct_i   (funct),
      .alu_ctl_o (dec_alu),
      .illegal_o (dec_illegal)
   );

   function automatic ctl_t moore_ctl(state_t s, logic [5:0] op, logic [3:0] alu);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read = 1'b1;  c.alu_src_b = SRCB_FOUR;  c.alu_ctl = ALU_ADD;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM_SH;  c.alu_ctl = ALU_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;  c.alu_src_b = SRCB_RT;  c.alu_ctl = alu;
         end
         S_WB_R: begin
            c.reg_write = 1'b1;  c.reg_dst = REGDST_RD;  c.mem_to_reg = M2R_ALUOUT;
         end
         S_EXEC_I: begin
            c.alu_src_a = 1'b1;  c.alu_src_b = SRCB_IMM;  c.alu_ctl = alu;
         end
         S_WB_I:     begin c.reg_write = 1'b1;  c.reg_dst = REGDST_RT; end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;  c.alu_src_b = SRCB_IMM;  c.alu_ctl = ALU_ADD;
         end
         S_MEM_RD:   begin c.mem_read = 1'b1;  c.iord = 1'b1; end
         S_MEM_WB: begin
            c.reg_write = 1'b1;  c.reg_dst = REGDST_RT;  c.mem_to_reg = M2R_MDR;
         end
         S_MEM_WR:   begin c.mem_write = 1'b1;  c.iord = 1'b1; end
         S_BRANCH: begin
            c.alu_src_a  = 1'b1;          c.alu_src_b = SRCB_RT;  c.alu_ctl = ALU_SUB;
            c.pc_write_c = 1'b1;          c.pc_src    = PCSRC_ALUOUT;
            c.beqorne    = op[0];
         end
         S_JUMP: begin
            c.pc_write = 1'b1;
            c.pc_src   = (op == OP_RTYPE) ? PCSRC_RS : PCSRC_JUMP;
            if (op == OP_JAL) begin
               c.reg_write = 1'b1;  c.reg_dst = REGDST_R31;  c.mem_to_reg = M2R_PC;
            end
         end
         S_WB_LUI: begin
            c.reg_write = 1'b1;  c.reg_dst = REGDST_RT;  c.mem_to_reg = M2R_LUI;
         end
         S_TRAP:     begin c.pc_write = 1'b1;  c.pc_src = PCSRC_JUMP; end
         default:    c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      in_mem  = is_mem_state(state_q);
      timeout = (MEM_TIMEOUT != 0) && in_mem && !mem_ready &&
                (cnt_q == TMO_W'(MEM_TIMEOUT - 1));
      cnt_d   = (in_mem && !mem_ready && !timeout) ? cnt_q + TMO_W'(1) : '0;

      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (dec_illegal) state_d = ILL_NEXT;
            else begin
               case (opcode)
                  OP_RTYPE:  state_d = (funct == FN_JR) ? S_JUMP : S_EXEC_R;
                  OP_LW, OP_SW: state_d = S_MEM_ADDR;
                  OP_BEQ, OP_BNE: state_d = S_BRANCH;
                  OP_J, OP_JAL: state_d = S_JUMP;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                  OP_LUI:    state_d = S_WB_LUI;
                  default:   state_d = ILL_NEXT;
               endcase
            end
         end
         S_EXEC_R:   state_d = S_WB_R;
         S_EXEC_I:   state_d = S_WB_I;
         S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (timeout)        state_d = S_FETCH;
            else if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WR:   if (timeout || mem_ready) state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase

      // Control word is precomputed for the next state so outputs come from flops;
      // the error/illegal pulses therefore land in the cycle after the event.
      ctl_d         = moore_ctl(state_d, opcode, dec_alu);
      ctl_d.mem_err = timeout;
      ctl_d.illegal = (state_q == S_DECODE) && dec_illegal;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ctl_q   <= moore_ctl(S_FETCH, '0, '0);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fetch_done = !rst && (state_q == S_FETCH) && mem_ready;

   assign mem_read   = !rst && ctl_q.mem_read;
   assign mem_write  = !rst && ctl_q.mem_write;
   assign iord       = !rst && ctl_q.iord;
   assign ir_write   = fetch_done;
   assign pc_write   = (!rst && ctl_q.pc_write) || fetch_done;
   assign pc_write_c = !rst && ctl_q.pc_write_c;
   assign beqorne    = !rst && ctl_q.beqorne;
   assign pc_src     = rst ? '0 : ctl_q.pc_src;
   assign alu_src_a  = !rst && ctl_q.alu_src_a;
   assign alu_src_b  = rst ? '0 : ctl_q.alu_src_b;
   assign alu_ctl    = rst ? '0 : ALUCTL_W'(ctl_q.alu_ctl);
   assign reg_write  = !rst && ctl_q.reg_write;
   assign reg_dst    = rst ? '0 : ctl_q.reg_dst;
   assign mem_to_reg = rst ? '0 : ctl_q.mem_to_reg;
   assign mem_err    = !rst && ctl_q.mem_err;
   assign illegal    = !rst && ctl_q.illegal;

endmodule
